// File: rtl/alu_share_pkg.sv
// Shared types and constants for the ALU sharing controller.
//
// Contents:
//   state_t  - controller FSM states (IDLE, EXEC, RESP)
//   OP_W     - opcode width seen by the ALU
//   OP_ADD   - opcode value for addition
package alu_share_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_ADD = 4'h0;

endpackage

// File: rtl/alu_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter used by alu_share_ctrl.
//
// Ports:
//   req    in  NREQ  request vector
//   ptr    in  PW    index searched first; the search wraps upward from here
//   en     in  1     when low, no grant is issued
//   grant  out NREQ  one-hot grant (all zero if nothing requested or disabled)
//
// The pointer itself is owned by the parent. Tying ptr to zero turns this
// into a fixed lowest-index-wins arbiter.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int PW   = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    input  logic            en,
    output logic [NREQ-1:0] grant
);

    int   idx;
    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (en && !found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Time-shares one external registered ALU between NREQ requesters.
//
// A requester is picked (round-robin by default), its operands and opcode
// are latched onto the ALU inputs, and after ALU_LAT cycles the ALU result
// is captured and returned on a single response channel tagged with the
// requester index.
//
// Build option: define ALU_SHARE_FIXED_PRIO_EN for fixed priority (lowest
// index wins, no round-robin pointer).
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid / req_ready   per-requester handshake (ready is one-hot)
//   req_a, req_b, req_op    packed per-requester operands and opcode
//   alu_a, alu_b, alu_op    operands/opcode held on the ALU inputs
//   alu_result              result coming back from the ALU
//   rsp_valid / rsp_ready   response handshake
//   rsp_id, rsp_result      issuing requester and its captured result
//   busy                    high whenever the controller is not IDLE
module alu_share_ctrl
    import alu_share_pkg::*;
#(
    parameter  int NREQ    = 2,
    parameter  int ALU_LAT = 1,
    parameter  int W       = 64,
    localparam int ID_W    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*W-1:0]  req_a,
    input  logic [NREQ*W-1:0]  req_b,
    input  logic [NREQ*OP_W-1:0] req_op,
    output logic [W-1:0]       alu_a,
    output logic [W-1:0]       alu_b,
    output logic [OP_W-1:0]    alu_op,
    input  logic [W-1:0]       alu_result,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [ID_W-1:0]    rsp_id,
    output logic [W-1:0]       rsp_result,
    output logic               busy
);

    localparam int CNT_W = 2;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ID_W-1:0]   tag_q, tag_d;
    logic [W-1:0]      alu_a_q, alu_a_d;
    logic [W-1:0]      alu_b_q, alu_b_d;
    logic [OP_W-1:0]   alu_op_q, alu_op_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic [W-1:0]      rsp_result_q, rsp_result_d;

    logic [NREQ-1:0]   grant;
    logic [ID_W-1:0]   arb_ptr;
    logic              arb_en;
    logic [ID_W-1:0]   grant_idx;
    logic [W-1:0]      sel_a, sel_b;
    logic [OP_W-1:0]   sel_op;

`ifdef ALU_SHARE_FIXED_PRIO_EN
    assign arb_ptr = '0;
`else
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    assign arb_ptr = rr_ptr_q;
`endif

    // rst_n is folded in so req_ready stays low while reset is held, even
    // though the state register already reads IDLE.
    assign arb_en = (state_q == IDLE) && rst_n;

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (ID_W)
    ) u_arb (
        .req   (req_valid),
        .ptr   (arb_ptr),
        .en    (arb_en),
        .grant (grant)
    );

    assign req_ready  = grant;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign busy       = (state_q != IDLE);

    // One-hot grant to index, and the granted requester's operand slice.
    always_comb begin
        grant_idx = '0;
        sel_a     = '0;
        sel_b     = '0;
        sel_op    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                grant_idx = ID_W'(i);
                sel_a     = req_a[i*W +: W];
                sel_b     = req_b[i*W +: W];
                sel_op    = req_op[i*OP_W +: OP_W];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        tag_d        = tag_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
`ifndef ALU_SHARE_FIXED_PRIO_EN
        rr_ptr_d     = rr_ptr_q;
`endif
        case (state_q)
            IDLE: begin
                // A grant only exists for a valid requester, so any grant
                // bit is a completed handshake.
                if (|grant) begin
                    alu_a_d  = sel_a;
                    alu_b_d  = sel_b;
                    alu_op_d = sel_op;
                    tag_d    = grant_idx;
                    cnt_d    = CNT_W'(ALU_LAT - 1);
                    state_d  = EXEC;
`ifndef ALU_SHARE_FIXED_PRIO_EN
                    rr_ptr_d = (grant_idx == ID_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
`endif
                end
            end
            EXEC: begin
                if (cnt_q == '0) begin
                    rsp_result_d = alu_result;
                    rsp_id_d     = tag_q;
                    rsp_valid_d  = 1'b1;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            tag_q        <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tag_q        <= tag_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
        end
    end

`ifndef ALU_SHARE_FIXED_PRIO_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed self-checking bench for alu_share_ctrl (NREQ=2, ALU_LAT=1, W=64).
// The external ALU is modelled here; with ALU_LAT=1 its result for the
// operands on alu_a/alu_b/alu_op is present during the cycle after they
// were latched, which is when the controller captures it.
module tb_alu_share_ctrl;
    import alu_share_pkg::*;

    localparam int NREQ    = 2;
    localparam int ALU_LAT = 1;
    localparam int W       = 64;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ*4-1:0] req_op;
    logic [W-1:0]      alu_a;
    logic [W-1:0]      alu_b;
    logic [3:0]        alu_op;
    logic [W-1:0]      alu_result;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [0:0]        rsp_id;
    logic [W-1:0]      rsp_result;
    logic              busy;

    int compared;
    int mismatched;

    alu_share_ctrl #(
        .NREQ    (NREQ),
        .ALU_LAT (ALU_LAT),
        .W       (W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] aluModel(input logic [W-1:0] a,
                                              input logic [W-1:0] b,
                                              input logic [3:0]   op);
        case (op)
            4'h0:    return a + b;
            4'h1:    return a - b;
            4'h2:    return a & b;
            4'h3:    return a | b;
            default: return a ^ b;
        endcase
    endfunction

    assign alu_result = aluModel(alu_a, alu_b, alu_op);

    task automatic waitCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0]  valid,
                                 input logic [63:0] a0, input logic [63:0] b0,
                                 input logic [3:0]  op0,
                                 input logic [63:0] a1, input logic [63:0] b1,
                                 input logic [3:0]  op1,
                                 input logic        rdy);
        req_valid = valid;
        req_a     = {a1, a0};
        req_b     = {b1, b0};
        req_op    = {op1, op0};
        rsp_ready = rdy;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    int expIds[4];

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        req_op     = '0;
        rsp_ready  = 1'b0;
`ifdef ALU_SHARE_FIXED_PRIO_EN
        expIds = '{0, 0, 0, 0};
`else
        expIds = '{1, 0, 1, 0};
`endif

        // Reset values
        #12;
        checkOutput("reset_req_ready", 64'(req_ready), 64'h0);
        checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'h0);
        checkOutput("reset_rsp_id", 64'(rsp_id), 64'h0);
        checkOutput("reset_rsp_result", rsp_result, 64'h0);
        checkOutput("reset_alu_a", alu_a, 64'h0);
        checkOutput("reset_alu_op", 64'(alu_op), 64'h0);
        checkOutput("reset_busy", 64'(busy), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        waitCycle();

        // Single request from requester 0: 5 + 7
        applyStimulus(2'b01, 64'h5, 64'h7, OP_ADD, 64'h0, 64'h0, 4'h0, 1'b1);
        checkOutput("single_req_ready", 64'(req_ready), 64'h1);
        checkOutput("single_busy_idle", 64'(busy), 64'h0);
        waitCycle();
        applyStimulus(2'b00, 64'h0, 64'h0, 4'h0, 64'h0, 64'h0, 4'h0, 1'b1);
        checkOutput("single_busy_exec", 64'(busy), 64'h1);
        checkOutput("single_ready_exec", 64'(req_ready), 64'h0);
        checkOutput("single_alu_a", alu_a, 64'h5);
        checkOutput("single_alu_b", alu_b, 64'h7);
        checkOutput("single_rsp_valid_early", 64'(rsp_valid), 64'h0);
        waitCycle();
        checkOutput("single_rsp_valid", 64'(rsp_valid), 64'h1);
        checkOutput("single_rsp_id", 64'(rsp_id), 64'h0);
        checkOutput("single_rsp_result", rsp_result, 64'hC);
        waitCycle();
        checkOutput("single_rsp_done", 64'(rsp_valid), 64'h0);
        checkOutput("single_busy_done", 64'(busy), 64'h0);

        // Both requesters valid continuously; pointer now points at 1
        applyStimulus(2'b11, 64'h1, 64'h2, OP_ADD, 64'hA, 64'h14, OP_ADD, 1'b1);
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("rr%0d_grant", k), 64'(req_ready),
                        64'(1) << expIds[k]);
            waitCycle();
            checkOutput($sformatf("rr%0d_ready_exec", k), 64'(req_ready), 64'h0);
            waitCycle();
            checkOutput($sformatf("rr%0d_rsp_id", k), 64'(rsp_id), 64'(expIds[k]));
            checkOutput($sformatf("rr%0d_rsp_result", k), rsp_result,
                        (expIds[k] == 1) ? 64'h1E : 64'h3);
            waitCycle();
        end
        applyStimulus(2'b00, 64'h0, 64'h0, 4'h0, 64'h0, 64'h0, 4'h0, 1'b1);

        // Backpressure with a subtract opcode from requester 1
        applyStimulus(2'b10, 64'h0, 64'h0, 4'h0, 64'h1234, 64'h1111, 4'h1, 1'b0);
        checkOutput("bp_grant", 64'(req_ready), 64'h2);
        waitCycle();
        applyStimulus(2'b11, 64'h0, 64'h0, 4'h0, 64'h1234, 64'h1111, 4'h1, 1'b0);
        checkOutput("bp_alu_op", 64'(alu_op), 64'h1);
        checkOutput("bp_alu_a", alu_a, 64'h1234);
        waitCycle();
        checkOutput("bp_rsp_valid", 64'(rsp_valid), 64'h1);
        checkOutput("bp_rsp_id", 64'(rsp_id), 64'h1);
        checkOutput("bp_rsp_result", rsp_result, 64'h0123);
        for (int k = 0; k < 5; k++) begin
            waitCycle();
            checkOutput($sformatf("bp%0d_valid", k), 64'(rsp_valid), 64'h1);
            checkOutput($sformatf("bp%0d_result", k), rsp_result, 64'h0123);
            checkOutput($sformatf("bp%0d_ready", k), 64'(req_ready), 64'h0);
            checkOutput($sformatf("bp%0d_busy", k), 64'(busy), 64'h1);
        end
        applyStimulus(2'b00, 64'h0, 64'h0, 4'h0, 64'h0, 64'h0, 4'h0, 1'b1);
        waitCycle();
        checkOutput("bp_release_valid", 64'(rsp_valid), 64'h0);
        checkOutput("bp_release_busy", 64'(busy), 64'h0);
        waitCycle();
        checkOutput("bp_stays_idle", 64'(busy), 64'h0);

        // Wrap-around addition from requester 0
        applyStimulus(2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, OP_ADD,
                      64'h0, 64'h0, 4'h0, 1'b1);
        checkOutput("wrap_grant", 64'(req_ready), 64'h1);
        waitCycle();
        applyStimulus(2'b00, 64'h0, 64'h0, 4'h0, 64'h0, 64'h0, 4'h0, 1'b1);
        waitCycle();
        checkOutput("wrap_rsp_valid", 64'(rsp_valid), 64'h1);
        checkOutput("wrap_rsp_id", 64'(rsp_id), 64'h0);
        checkOutput("wrap_rsp_result", rsp_result, 64'h0);
        waitCycle();

        // Valid dropped in IDLE before any edge: nothing happens
        applyStimulus(2'b10, 64'h0, 64'h0, 4'h0, 64'h9, 64'h9, 4'h0, 1'b1);
        checkOutput("drop_ready_seen", 64'(req_ready), 64'h2);
        applyStimulus(2'b00, 64'h0, 64'h0, 4'h0, 64'h9, 64'h9, 4'h0, 1'b1);
        checkOutput("drop_ready_gone", 64'(req_ready), 64'h0);
        waitCycle();
        checkOutput("drop_busy", 64'(busy), 64'h0);

        // Reset asserted during EXEC, then a normal transaction
        applyStimulus(2'b10, 64'h0, 64'h0, 4'h0, 64'h3, 64'h4, 4'h3, 1'b1);
        waitCycle();
        checkOutput("rst_exec_busy", 64'(busy), 64'h1);
        checkOutput("rst_exec_alu_a", alu_a, 64'h3);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_async_alu_a", alu_a, 64'h0);
        checkOutput("rst_async_alu_b", alu_b, 64'h0);
        checkOutput("rst_async_alu_op", 64'(alu_op), 64'h0);
        checkOutput("rst_async_busy", 64'(busy), 64'h0);
        checkOutput("rst_async_ready", 64'(req_ready), 64'h0);
        checkOutput("rst_async_rsp_valid", 64'(rsp_valid), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("post_rst_grant", 64'(req_ready), 64'h2);
        checkOutput("post_rst_no_rsp", 64'(rsp_valid), 64'h0);
        waitCycle();
        applyStimulus(2'b00, 64'h0, 64'h0, 4'h0, 64'h0, 64'h0, 4'h0, 1'b1);
        waitCycle();
        checkOutput("post_rst_rsp_valid", 64'(rsp_valid), 64'h1);
        checkOutput("post_rst_rsp_id", 64'(rsp_id), 64'h1);
        checkOutput("post_rst_rsp_result", rsp_result, 64'h7);
        waitCycle();
        checkOutput("post_rst_idle", 64'(busy), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Time-shares one registered 64-bit ALU (4-bit opcode, result registered on clk) between NREQ requesters.
- Per requester: valid/ready handshake. Grants are round-robin; operands are latched and applied to the ALU for ALU_LAT cycles.
- Each result is returned on a single response channel tagged with the requester ID.
- Sits between bus-side command sources and the ALU datapath; the ALU itself is an external instance.

Parameters:
- NREQ, 2, number of requesters (2..8)
- ALU_LAT, 1, cycles from the ALU operand/op being presented to the result being valid (1..4)
- W, 64, operand/result width

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  request pending, one bit per requester
- req_ready  out  NREQ  one-hot accept strobe
- req_a  in  NREQ*W  operand A, packed, requester i at [i*W +: W]
- req_b  in  NREQ*W  operand B, packed the same way
- req_op  in  NREQ*4  opcode, packed [i*4 +: 4]
- alu_a  out  W  operand A to the ALU
- alu_b  out  W  operand B to the ALU
- alu_op  out  4  opcode to the ALU
- alu_result  in  W  registered ALU result
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumer accepts
- rsp_id  out  $clog2(NREQ) (min 1)  requester that issued the operation
- rsp_result  out  W  captured result
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async assert, sync-release usage): state=IDLE; req_ready=0; rsp_valid=0; rsp_id=0; rsp_result=0; alu_a=alu_b=0; alu_op=0; rr_ptr=0; busy=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid: grant the first set bit searching from rr_ptr upward with wrap.
  - Assert req_ready[g] combinationally in that cycle; handshake = valid&ready.
  - On the handshake edge: latch a/b/op into alu_a/alu_b/alu_op, store g as tag, rr_ptr <= (g+1) mod NREQ, cnt <= ALU_LAT-1, go to EXEC.
  - No req_valid: stay in IDLE, all req_ready=0.
- EXEC:
  - alu_a/b/op held stable.
  - If cnt==0, the edge that ends this cycle captures alu_result into rsp_result, sets rsp_id=tag and rsp_valid=1, then goes to RESP.
  - Otherwise cnt decrements each cycle.
  - With ALU_LAT=1, EXEC lasts exactly one cycle.
- RESP:
  - rsp_valid=1; rsp_result/rsp_id held until rsp_valid&rsp_ready.
  - On that edge: rsp_valid <= 0, go to IDLE.
- req_ready is 0 in EXEC and RESP.
- Minimum issue-to-issue spacing is ALU_LAT+2 cycles.
- Accept-to-rsp_valid latency is ALU_LAT+1 edges.
- Fairness: a requester that holds valid continuously is granted within NREQ grants.
- Requesters may drop valid in IDLE before ready; there is no penalty and no state change.
- Opcodes are passed through unmodified; no width or arithmetic changes in this block.
- Reset mid-EXEC or mid-RESP: everything returns to reset values, and the in-flight result is discarded without a response.
- rsp_ready held high permanently: RESP still lasts one cycle (no bypass to IDLE in the same edge).

Optional Feature:
- Macro: ALU_SHARE_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins; rr_ptr is not implemented and the grant is independent of history.
- Undefined: round-robin as described above.

Decomposition:
- Package alu_share_pkg:
  - typedef enum logic[1:0] {IDLE, EXEC, RESP} state_t
  - localparam OP_W=4
  - opcode constant OP_ADD=4'h0
- One natural sub-module: rr_arbiter.
  - Inputs: NREQ req vector, ptr, enable. Output: one-hot grant.
  - Combinational grant; the pointer update lives in the parent.
  - Reused under the fixed-priority macro with ptr tied to 0.

Test Plan:
- Single request: req0 a=64'h5, b=64'h7, op=0 with rsp_ready=1 → req_ready[0] same cycle; rsp_valid after 2 edges (ALU_LAT=1) with rsp_id=0, rsp_result=64'hC.
- Both valid continuously, op=0, rsp_ready=1 → grants alternate 0,1,0,1; with fixed-prio build, 0 always wins.
- Backpressure: rsp_ready=0 for 5 cycles → rsp_valid and rsp_result stable, req_ready stays 0, busy=1; rsp_ready=1 → one transfer, then IDLE.
- ALU_LAT=3 build: accept at cycle t → alu_op/operands constant t+1..t+3, rsp_valid at edge t+4.
- Reset asserted during EXEC → all outputs zero immediately (async); after release, the next request completes normally with rsp_id correct.
- Wrap: 64'hFFFF_FFFF_FFFF_FFFF + 64'h1 → rsp_result=64'h0.
